// File: rtl/regxfer_if.sv
// Handshake and register-bank strobe bundle between requesters and regxfer_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface regxfer_if #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int SELW = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] src_sel;
    logic [NREQ*SELW-1:0] dst_sel;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic [NREQ-1:0]      grant;
    logic [NREG-1:0]      reg_oe_n;
    logic [NREG-1:0]      reg_ld;
    logic                 busy;

    modport master (
        output req, src_sel, dst_sel,
        input  ack, err, grant, reg_oe_n, reg_ld, busy
    );

    modport slave (
        input  req, src_sel, dst_sel,
        output ack, err, grant, reg_oe_n, reg_ld, busy
    );
endinterface

// File: rtl/regxfer_arbiter.sv
// Round-robin owner of the shared register bus: one /OE low, then one load strobe, per transfer.
// Optional macro REGXFER_TURNAROUND_EN inserts a dead-bus TURN cycle after RELEASE.
module regxfer_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic     clk,
    input  logic     rst,
    regxfer_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REGXFER_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, DRIVE, LATCH, RELEASE, TURN} state_t;
`else
    typedef enum logic [2:0] {IDLE, DRIVE, LATCH, RELEASE} state_t;
`endif

    state_t          state_reg;
    logic [GW-1:0]   rr_reg;
    logic [GW-1:0]   gidx_reg;
    logic [SELW-1:0] src_reg;
    logic [SELW-1:0] dst_reg;
    logic            illegal_reg;
    logic [NREQ-1:0] grant_reg;
    logic [NREQ-1:0] ack_reg;
    logic [NREQ-1:0] err_reg;
    logic [NREG-1:0] oe_n_reg;
    logic [NREG-1:0] ld_reg;
    logic            busy_reg;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [GW-1:0]     rot_off;
    logic [GW-1:0]     win;
    logic [NREQ-1:0]   win_oh;
    logic [SELW-1:0]   src_arr [NREQ];
    logic [SELW-1:0]   dst_arr [NREQ];
    logic [SELW-1:0]   win_src;
    logic [SELW-1:0]   win_dst;
    logic              win_illegal;
    logic [NREG-1:0]   src_oh;
    logic [NREG-1:0]   dst_oh;

    // Rotate requests so bit 0 is the rr pointer; the lowest set bit is then the winner.
    assign req_dbl = {bus.req, bus.req} >> rr_reg;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        rot_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) rot_off = GW'(k);
        end
    end

    assign win = GW'((int'(rr_reg) + int'(rot_off)) % NREQ);

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign src_arr[gi] = bus.src_sel[gi*SELW +: SELW];
        assign dst_arr[gi] = bus.dst_sel[gi*SELW +: SELW];
        assign win_oh[gi]  = (int'(win) == gi);
    end

    assign win_src     = src_arr[win];
    assign win_dst     = dst_arr[win];
    assign win_illegal = (win_src == win_dst) || (int'(win_src) >= NREG) || (int'(win_dst) >= NREG);

    // Decoders are gated by the latched illegal flag so a bad transfer never touches the bank.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        assign src_oh[gi] = (int'(src_reg) == gi) && !illegal_reg;
        assign dst_oh[gi] = (int'(dst_reg) == gi) && !illegal_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            gidx_reg    <= '0;
            src_reg     <= '0;
            dst_reg     <= '0;
            illegal_reg <= 1'b0;
            grant_reg   <= '0;
            ack_reg     <= '0;
            err_reg     <= '0;
            oe_n_reg    <= '1;
            ld_reg      <= '0;
            busy_reg    <= 1'b0;
        end else begin
            ack_reg <= '0;
            err_reg <= '0;
            ld_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.req != '0) begin
                        gidx_reg    <= win;
                        src_reg     <= win_src;
                        dst_reg     <= win_dst;
                        illegal_reg <= win_illegal;
                        grant_reg   <= win_oh;
                        busy_reg    <= 1'b1;
                        state_reg   <= DRIVE;
                    end
                end
                DRIVE: begin
                    oe_n_reg  <= ~src_oh;
                    state_reg <= LATCH;
                end
                LATCH: begin
                    ld_reg    <= dst_oh;
                    state_reg <= RELEASE;
                end
                RELEASE: begin
                    oe_n_reg  <= '1;
                    ack_reg   <= grant_reg;
                    err_reg   <= illegal_reg ? grant_reg : '0;
                    grant_reg <= '0;
                    rr_reg    <= GW'((int'(gidx_reg) + 1) % NREQ);
`ifdef REGXFER_TURNAROUND_EN
                    state_reg <= TURN;
                end
                TURN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
`else
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ack      = ack_reg;
    assign bus.err      = err_reg;
    assign bus.grant    = grant_reg;
    assign bus.reg_oe_n = oe_n_reg;
    assign bus.reg_ld   = ld_reg;
    assign bus.busy     = busy_reg;
endmodule
